// File: rtl/dist_law_if.sv
// dist_law_if: start/busy/done handshake and operand/result bus for dist_law_seq.
interface dist_law_if #(parameter int W = 8);
  logic start, busy, done, mismatch;
  logic [W-1:0] a, b, c;
  logic [2*W:0] out1, out2;
  modport master (output start, a, b, c, input busy, done, out1, out2, mismatch);
  modport slave (input start, a, b, c, output busy, done, out1, out2, mismatch);
endinterface

// File: rtl/dist_law_seq.sv
// dist_law_seq: a*(b+c) and a*b+a*c via one shared radix-2 Booth engine; DIST_LAW_CHECK_EN enables the mismatch comparator.
module dist_law_seq #(parameter int W = 8) (
  input logic clk,
  input logic rst_n,
  dist_law_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MUL_S, MUL_B, MUL_C, FIN} state_t;
  localparam int CW = $clog2(W);
  state_t state;
  logic [CW-1:0] cnt;
  logic [W-1:0] a_r, b_r, c_r, q, nq;
  logic [W:0] s_r, mx;
  logic [W+1:0] acc, sum, nacc;
  logic [2*W+1:0] full;
  logic [2*W:0] prod, p_s, p_b, p_c, p_bc, o1, o2;
  logic q1, busy, done, mm;
  always_comb begin
    mx = state == MUL_S ? s_r : state == MUL_B ? {b_r[W-1], b_r} : {c_r[W-1], c_r};
    sum = (q[0] && !q1) ? acc - {mx[W], mx} : (!q[0] && q1) ? acc + {mx[W], mx} : acc;
    nacc = {sum[W+1], sum[W+1:1]};
    nq = {sum[0], q[W-1:1]};
    full = {nacc, nq};
    prod = full[2*W:0];
    p_bc = p_b + p_c;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      {a_r, b_r, c_r, s_r, acc, q, q1} <= '0;
      {p_s, p_b, p_c, o1, o2} <= '0;
      {busy, done, mm} <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          a_r <= bus.a;
          b_r <= bus.b;
          c_r <= bus.c;
          s_r <= {bus.b[W-1], bus.b} + {bus.c[W-1], bus.c};
          acc <= '0;
          q <= bus.a;
          q1 <= 1'b0;
          cnt <= '0;
          busy <= 1'b1;
          state <= MUL_S;
        end
        MUL_S, MUL_B, MUL_C: begin
          acc <= nacc;
          q <= nq;
          q1 <= q[0];
          cnt <= cnt + 1'b1;
          // last step: bank the product and reload the engine for the next multiplicand
          if (cnt == CW'(W-1)) begin
            cnt <= '0;
            acc <= '0;
            q <= a_r;
            q1 <= 1'b0;
            if (state == MUL_S) p_s <= prod;
            if (state == MUL_B) p_b <= prod;
            if (state == MUL_C) p_c <= prod;
            state <= state == MUL_S ? MUL_B : state == MUL_B ? MUL_C : FIN;
          end
        end
        FIN: begin
          o1 <= p_s;
          o2 <= p_bc;
`ifdef DIST_LAW_CHECK_EN
          mm <= p_s != p_bc;
`endif
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.out1 = o1;
  assign bus.out2 = o2;
  assign bus.mismatch = mm;
endmodule

// File: tb/tb_dist_law_seq.sv
// tb_dist_law_seq: directed W=4 corner/handshake/reset checks and W=8 random back-to-back run against a*(b+c).
module tb_dist_law_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  dist_law_if #(4) b4 ();
  dist_law_if #(8) b8 ();
  dist_law_seq #(.W(4)) d4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  dist_law_seq #(.W(8)) d8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run4(input string tag, input int a, input int b, input int c);
    int n, e;
    e = a * (b + c);
    @(negedge clk);
    b4.a = 4'(a); b4.b = 4'(b); b4.c = 4'(c); b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    chk({tag, "_busy_hi"}, b4.busy, 1);
    n = 0;
    while (b4.done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_latency"}, n, 13);
    chk({tag, "_out1"}, $signed(b4.out1), e);
    chk({tag, "_out2"}, $signed(b4.out2), e);
    chk({tag, "_mismatch"}, b4.mismatch, 0);
    chk({tag, "_busy_lo"}, b4.busy, 0);
  endtask

  initial begin
    int n, lows, dones, e;
    logic signed [7:0] ra, rb, rc;
    int q[$];
    {b4.start, b4.a, b4.b, b4.c} = '0;
    {b8.start, b8.a, b8.b, b8.c} = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", b4.busy, 0);
    chk("rst_done", b4.done, 0);
    chk("rst_out1", b4.out1, 0);
    chk("rst_out2", b4.out2, 0);
    chk("rst_mismatch", b4.mismatch, 0);
    rst_n = 1'b1;
    run4("basic", 3, 2, -5);
    run4("wide_sum", -8, 7, 7);
    run4("neg_corner", -8, -8, -8);
    run4("zero_a", 0, 5, -3);
    run4("pos", 7, 7, -8);
    // start pulses while busy must be ignored
    @(negedge clk);
    b4.a = 4'd3; b4.b = 4'd2; b4.c = 4'(-5); b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    n = 0; lows = 0;
    while (b4.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (b4.done !== 1'b1 && b4.busy !== 1'b1) lows++;
      b4.start = (n == 3 || n == 8);
      if (b4.start) begin b4.a = 4'd2; b4.b = 4'd2; b4.c = 4'd2; end
    end
    chk("ign_latency", n, 13);
    chk("ign_busy_gap", lows, 0);
    chk("ign_out1", $signed(b4.out1), -9);
    chk("ign_out2", $signed(b4.out2), -9);
    dones = 0;
    repeat (30) begin @(negedge clk); if (b4.done === 1'b1) dones++; end
    chk("ign_no_second_done", dones, 0);
    chk("ign_idle_busy", b4.busy, 0);
    // asynchronous reset mid-operation
    @(negedge clk);
    b4.a = 4'd5; b4.b = 4'd1; b4.c = 4'd1; b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", b4.busy, 0);
    chk("mid_rst_done", b4.done, 0);
    chk("mid_rst_out1", b4.out1, 0);
    chk("mid_rst_out2", b4.out2, 0);
    chk("mid_rst_mismatch", b4.mismatch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run4("after_rst", -3, 4, -6);
    // W=8 random back-to-back with start held high
    @(negedge clk);
    ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
    b8.a = ra; b8.b = rb; b8.c = rc; b8.start = 1'b1;
    q.push_back(int'(ra) * (int'(rb) + int'(rc)));
    for (int i = 0; i < 1500; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (b8.done !== 1'b1 && n < 60);
      chk("rnd_spacing", n, 26);
      e = q.pop_front();
      chk("rnd_out1", $signed(b8.out1), e);
      chk("rnd_out2", $signed(b8.out2), e);
      chk("rnd_mismatch", b8.mismatch, 0);
      ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
      b8.a = ra; b8.b = rb; b8.c = rc;
      q.push_back(int'(ra) * (int'(rb) + int'(rc)));
    end
    b8.start = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
